seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
//
// PURPOSE
// Time-multiplexes a packed NUM_DIGITS x 4-bit display word onto one shared 7-seg bus.
// Each scan slot drives one nibble on y, which feeds bcd7seg, plus active-low anodes and decimal point.
// New words are shadow-buffered and committed only at a frame boundary, so a display never mixes old and new digits.
// Sits between the scoreboard/score logic (value producer) and bcd7seg/board pins.
//
// PARAMETERS
// NUM_DIGITS    4       digits scanned; idx width = $clog2(NUM_DIGITS), min 2.
// REFRESH_DIV   100000  SHOW cycles per digit slot, >=1 (100 MHz -> 1 ms/digit).
// GUARD_CYCLES  16      all-anodes-off cycles before each slot, >=0 (anti-ghosting).
//
// PORTS
// clk       in   1             system clock, all logic on rising edge
// rst_n     in   1             synchronous active-low reset
// load      in   1             1-cycle strobe: capture value/dp_mask into shadow
// value     in   4*NUM_DIGITS  nibble i = digit i (digit 0 = rightmost, bits [3:0])
// dp_mask   in   NUM_DIGITS    1 = light decimal point of digit i
// blank_mask in  NUM_DIGITS    1 = digit i dark (live, not shadowed)
// lz_en     in   1             1 = suppress leading zero digits (live)
// y         out  4             nibble to bcd7seg for current slot
// an        out  NUM_DIGITS    active-low anode enables, at most one low
// dp_n      out  1             active-low decimal point
// frame_start out 1            1-cycle pulse on entry to digit 0 SHOW
// pending   out  1             shadow holds an uncommitted word
//
// BEHAVIOUR
// - All outputs registered. Reset: an = all 1, y = 0, dp_n = 1, frame_start = 0, pending = 0,
//   committed word = 0, dp reg = 0, idx = NUM_DIGITS-1, state = GUARD, cnt = 0.
// - FSM GUARD: an = all 1, dp_n = 1. After GUARD_CYCLES cycles -> SHOW, idx <= idx+1 (wraps NUM_DIGITS-1 -> 0).
// - GUARD_CYCLES = 0: GUARD skipped; SHOW terminal goes directly to SHOW of next idx.
// - FSM SHOW: lasts exactly REFRESH_DIV cycles; then -> GUARD. cnt resets on every state entry.
// - First cycle of SHOW: y = committed nibble[idx], dp_n = ~dp reg[idx], an[idx] = 0 unless digit dark.
// - Digit dark if blank_mask[idx], or lz_en and idx>0 and nibbles idx..NUM_DIGITS-1 of committed word all 0.
//   Dark digit: an stays all 1, y still driven, dp_n = 1. Digit 0 never suppressed by lz_en.
// - Frame boundary: transition into SHOW with idx 0. In that same edge, if pending, commit shadow,
//   clear pending; the commit is visible in that slot. frame_start = 1 for that cycle only.
// - load: shadow <= value/dp_mask, pending <= 1 next cycle. A later load before commit overwrites the shadow.
//   A load in the same cycle as commit: the old shadow commits, the new word is captured, pending stays 1.
// - Frame period = NUM_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles. Worst-case load-to-visible latency
//   = one frame + 1 cycle.
// - rst_n low mid-frame: all state returns to reset values on that edge; shadow and pending are discarded.
// - Counter width = $clog2(max(REFRESH_DIV, GUARD_CYCLES, 2)). No arithmetic overflow is allowed.
//
// STRUCTURE
// - Shared package seg_pkg: state enum {GUARD, SHOW}, AN_OFF constant, default NUM_DIGITS.
// - One sub-module, seg_slot_timer: down-counter loaded with REFRESH_DIV-1 or GUARD_CYCLES-1,
//   emits a done pulse. The FSM, shadow/commit and blanking logic stay in seg_scan_mux.
// - bcd7seg is instantiated alongside, not inside, this block.
//
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2; frame = 24 cycles)
// - Reset release -> an=1111 for 2 cycles, then an=1110, y=0, frame_start=1; slots rotate 1101, 1011, 0111,
//   each 4 cycles, separated by 2-cycle guards.
// - load value=16'h1A2B mid-frame -> pending=1; display unchanged until next frame_start;
//   then y sequence B,2,A,1 and pending=0.
// - Two loads (16'h1111 then 16'h2222) within one frame -> only 2,2,2,2 is ever shown.
// - lz_en=1, value=16'h0050 -> digits 3 and 2 dark (an stays 1111 in their slots), digits 1 and 0 shown;
//   value=0 -> only digit 0 shown.
// - blank_mask=4'b0100, dp_mask=4'b0010 -> digit 2 slot dark; dp_n=0 only in digit 1 slot; dp_n=1 during guards.
// - rst_n low in digit 2 SHOW with pending=1 -> next cycle outputs at reset values, pending=0; old word not shown.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan logic.
package seg_pkg;

    localparam int SEG_NUM_DIGITS = 4;
    localparam int SEG_MAX_DIGITS = 16;

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    typedef enum logic [0:0] {
        GUARD = ST_GUARD,
        SHOW  = ST_SHOW
    } state_t;

    // All anodes released (active-low); sliced down to the real digit count by users.
    localparam logic [SEG_MAX_DIGITS-1:0] AN_OFF = '1;

    function automatic int seg_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Down-counter timing one scan slot; done is high while the count sits at zero.
module seg_slot_timer #(
    parameter int              CW      = 2,
    parameter logic [CW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    // Reset behaves as a fresh entry into the first guard slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Scans a shadow-buffered multi-digit word onto one shared 7-segment bus
// with guard gaps, blanking and leading-zero suppression.
import seg_pkg::*;

module seg_scan_mux #(
    parameter int NUM_DIGITS   = SEG_NUM_DIGITS,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [3:0]              y,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp_n,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(seg_max3(REFRESH_DIV, GUARD_CYCLES, 2));

    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    state_t                  state, state_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] shadow, word, word_nx;
    logic [NUM_DIGITS-1:0]   sh_dp, dp_reg, dp_nx;
    logic                    tmr_done, tmr_load, guard_done;
    logic [CW-1:0]           tmr_val;
    logic                    enter_show, enter_frame, commit, dark_nx;

    // A digit is dark when blanked, or when lz suppression applies: it and every
    // more-significant nibble are zero. Digit 0 always stays lit under lz.
    function automatic logic digit_dark(
        input logic [4*NUM_DIGITS-1:0] w,
        input logic [IW-1:0]           i,
        input logic [NUM_DIGITS-1:0]   blank,
        input logic                    lz
    );
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i) && w[4*k +: 4] != 4'd0) upper_zero = 1'b0;
        end
        return blank[i] || (lz && (i != '0) && upper_zero);
    endfunction

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IDX_LAST) ? '0 : i + IW'(1);
    endfunction

    seg_slot_timer #(
        .CW      (CW),
        .RST_VAL (GUARD_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign guard_done = (GUARD_CYCLES == 0) || tmr_done;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        enter_show = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = SHOW_LOAD;
        case (state)
            GUARD: begin
                if (guard_done) begin
                    state_nx   = SHOW;
                    idx_nx     = idx_inc(idx);
                    enter_show = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = SHOW_LOAD;
                end
            end
            SHOW: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (GUARD_CYCLES == 0) begin
                        state_nx   = SHOW;
                        idx_nx     = idx_inc(idx);
                        enter_show = 1'b1;
                        tmr_val    = SHOW_LOAD;
                    end else begin
                        state_nx = GUARD;
                        tmr_val  = GUARD_LOAD;
                    end
                end
            end
            default: begin
                state_nx = GUARD;
                tmr_load = 1'b1;
                tmr_val  = GUARD_LOAD;
            end
        endcase
    end

    // The commit lands on the same edge as the digit-0 slot entry, so the new
    // word is already what that slot latches onto the bus.
    assign enter_frame = enter_show && (idx_nx == '0);
    assign commit      = enter_frame && pending;
    assign word_nx     = commit ? shadow : word;
    assign dp_nx       = commit ? sh_dp  : dp_reg;
    assign dark_nx     = digit_dark(word_nx, idx_nx, blank_mask, lz_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= GUARD;
            idx         <= IDX_LAST;
            shadow      <= '0;
            sh_dp       <= '0;
            word        <= '0;
            dp_reg      <= '0;
            pending     <= 1'b0;
            y           <= 4'd0;
            an          <= AN_ALL_OFF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            word        <= word_nx;
            dp_reg      <= dp_nx;
            frame_start <= enter_frame;
            if (load) begin
                shadow <= value;
                sh_dp  <= dp_mask;
            end
            pending <= load | (pending & ~commit);

            if (enter_show) begin
                y    <= word_nx[4*idx_nx +: 4];
                an   <= dark_nx ? AN_ALL_OFF : ~(AN_ONE << idx_nx);
                dp_n <= dark_nx ? 1'b1 : ~dp_nx[idx_nx];
            end else if (state_nx == GUARD) begin
                an   <= AN_ALL_OFF;
                dp_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus random traffic against a
// slot/time based reference model.
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int G     = 2;
    localparam int SLOT  = R + G;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  y;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame_start;
    logic        pending;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model state: t counts cycles since the last reset edge.
    int          t = 0;
    logic [15:0] m_shadow = 16'h0, m_word = 16'h0;
    logic [3:0]  m_shdp = 4'h0, m_dp = 4'h0;
    logic        m_pend = 1'b0;
    logic [3:0]  m_y = 4'h0, m_an = 4'hF;
    logic        m_dpn = 1'b1, m_fs = 1'b0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .lz_en       (lz_en),
        .y           (y),
        .an          (an),
        .dp_n        (dp_n),
        .frame_start (frame_start),
        .pending     (pending)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Each slot is G guard cycles followed by R show cycles; slot s of a frame
    // shows digit s. Every show entry latches what the bus carries for the slot.
    task automatic model_edge();
        int   o, s;
        logic cm, dark;
        logic [3:0] oh;
        if (!rst_n) begin
            t = 0; m_shadow = 16'h0; m_shdp = 4'h0; m_pend = 1'b0;
            m_word = 16'h0; m_dp = 4'h0; m_y = 4'h0; m_an = 4'hF; m_dpn = 1'b1; m_fs = 1'b0;
        end else begin
            t++;
            o = t % SLOT;
            s = (t / SLOT) % N;
            m_fs = (o == G) && (s == 0);
            cm = m_fs && m_pend;
            if (cm) begin
                m_word = m_shadow;
                m_dp   = m_shdp;
            end
            if (load) begin
                m_shadow = value;
                m_shdp   = dp_mask;
                m_pend   = 1'b1;
            end else if (cm) begin
                m_pend = 1'b0;
            end
            if (o == G) begin
                dark  = blank_mask[s] || (lz_en && s > 0 && (m_word >> (4 * s)) == 16'h0);
                oh    = 4'b0001 << s;
                m_y   = m_word[4*s +: 4];
                m_an  = dark ? 4'hF : ~oh;
                m_dpn = dark ? 1'b1 : ~m_dp[s];
            end else if (o == 0) begin
                m_an  = 4'hF;
                m_dpn = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("an",          16'(an),          16'(m_an));
        check("y",           16'(y),           16'(m_y));
        check("dp_n",        16'(dp_n),        16'(m_dpn));
        check("frame_start", 16'(frame_start), 16'(m_fs));
        check("pending",     16'(pending),     16'(m_pend));
    endtask

    task automatic wait_phase(input int ph);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (t % FRAME == ph) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_asrt++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL wait_phase: phase %0d not reached, observed t=%0d", ph, t);
        end
    endtask

    task automatic load_word(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        // Reset held, then release and watch the first frames.
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_an", 16'(an), 16'hF);
        check("reset_pending", 16'(pending), 16'h0);
        rst_n = 1'b1;
        step();
        check("guard_after_release", 16'(an), 16'hF);
        step();
        check("first_slot_an", 16'(an), 16'hE);
        check("first_frame_start", 16'(frame_start), 16'h1);
        repeat (FRAME + 6) step();

        // Mid-frame load becomes visible only at the next frame.
        wait_phase(9);
        load_word(16'h1A2B);
        check("pending_after_load", 16'(pending), 16'h1);
        repeat (2 * FRAME) step();

        // Two loads within one frame: only the second is ever committed.
        wait_phase(4);
        load_word(16'h1111);
        repeat (5) step();
        load_word(16'h2222);
        repeat (2 * FRAME) step();

        // Leading-zero suppression.
        lz_en = 1'b1;
        load_word(16'h0050);
        repeat (2 * FRAME) step();
        load_word(16'h0000);
        repeat (2 * FRAME) step();
        lz_en = 1'b0;

        // Blanked digit and decimal point.
        blank_mask = 4'b0100;
        dp_mask    = 4'b0010;
        load_word(16'h1234);
        repeat (2 * FRAME) step();
        blank_mask = 4'b0000;
        dp_mask    = 4'b0000;

        // Load right at a frame edge (commit and capture on one edge).
        wait_phase(1);
        load_word(16'h5678);
        repeat (FRAME + 2) step();

        // Reset in the digit-2 slot while a word is pending.
        wait_phase(3);
        load_word(16'h9999);
        wait_phase(15);
        rst_n = 1'b0;
        step();
        check("mid_reset_pending", 16'(pending), 16'h0);
        check("mid_reset_an", 16'(an), 16'hF);
        rst_n = 1'b1;
        repeat (2 * FRAME) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            step();
        end
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (FRAME) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
